// File: rtl/therm_pkg.sv
// Shared types and constants for the thermometer measurement sequencer.
package therm_pkg;

    localparam int COUNT_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        SETTLE,
        MEASURE,
        CAPTURE,
        CLEAR,
        REPORT,
        WAIT_ACK,
        WAIT_TX,
        GAP,
        CLEAR_ABORT
    } state_t;

    // Width of a down-counter that must hold max_cyc-1 (the timer is loaded
    // with N-1 so that a phase lasts exactly N cycles).
    function automatic int timer_w(input int max_cyc);
        return (max_cyc < 2) ? 1 : $clog2(max_cyc);
    endfunction

endpackage

// File: rtl/therm_cyc_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module therm_cyc_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              cnt <= '0;
        else if (load)         cnt <= load_val;
        else if (cnt != '0)    cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/therm_meas_seq.sv
// Measurement sequencer for the ring-oscillator thermometer: settles the
// oscillator, collects 2^AVG_LOG2 windowed counts, averages them and hands
// the result to the UART. Optional macro THERM_ALARM_EN adds a threshold
// alarm (alarm_thresh input, alarm output) updated with each report.
module therm_meas_seq
    import therm_pkg::*;
#(
    parameter int AVG_LOG2    = 2,
    parameter int SETTLE_CYC  = 16,
    parameter int GAP_CYC     = 1000,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               single,
    input  logic               window_done,
    input  logic [COUNT_W-1:0] latch_count,
    input  logic               uart_busy,
    output logic               ro_en,
    output logic               uart_start,
    output logic [COUNT_W-1:0] avg_count,
    output logic               avg_valid,
    output logic               seq_busy,
    output logic               timeout_err
`ifdef THERM_ALARM_EN
    ,
    input  logic [COUNT_W-1:0] alarm_thresh,
    output logic               alarm
`endif
);

    localparam int NSMP = 1 << AVG_LOG2;
    localparam int AW   = COUNT_W + AVG_LOG2;
    localparam int SW   = AVG_LOG2 + 1;
    localparam int MAXC = (TIMEOUT_CYC > SETTLE_CYC) ?
                          ((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC) :
                          ((SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC);
    localparam int TW   = timer_w(MAXC);

    localparam logic [TW-1:0] SETTLE_LD = TW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [TW-1:0] GAP_LD    = TW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [TW-1:0] TMO_LD    = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t          state, state_nxt;
    logic            to_hit;
    logic            tmr_load, tmr_done;
    logic [TW-1:0]   tmr_ld;
    logic [AW-1:0]   acc, acc_sum;
    logic [SW-1:0]   smp_cnt;
    logic            last_smp;
    logic [COUNT_W-1:0] avg_new;

    assign acc_sum  = acc + AW'(latch_count);
    assign avg_new  = COUNT_W'(acc_sum >> AVG_LOG2);
    assign last_smp = (smp_cnt == SW'(NSMP - 1));

    // One timer serves SETTLE, GAP and every timeout; it is reloaded whenever
    // the state changes, with the length that belongs to the state entered.
    assign tmr_load = (state_nxt != state);

    // Pick the reload value for the state being entered.
    always_comb begin
        tmr_ld = TMO_LD;
        case (state_nxt)
            SETTLE:  tmr_ld = SETTLE_LD;
            GAP:     tmr_ld = GAP_LD;
            default: tmr_ld = TMO_LD;
        endcase
    end

    therm_cyc_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_ld),
        .done     (tmr_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; to_hit flags a transition caused by a timeout.
    always_comb begin
        state_nxt = state;
        to_hit    = 1'b0;
        case (state)
            IDLE:        if (run || single) state_nxt = SETTLE;
            SETTLE:      if (tmr_done) state_nxt = MEASURE;
            MEASURE: begin
                if (window_done)   state_nxt = CAPTURE;
                else if (tmr_done) begin
                    to_hit    = 1'b1;
                    state_nxt = CLEAR_ABORT;
                end
            end
            CAPTURE:     state_nxt = last_smp ? REPORT : CLEAR;
            CLEAR:       state_nxt = SETTLE;
            REPORT:      state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (uart_busy)     state_nxt = WAIT_TX;
                else if (tmr_done) begin
                    to_hit    = 1'b1;
                    state_nxt = GAP;
                end
            end
            WAIT_TX: begin
                if (!uart_busy)    state_nxt = GAP;
                else if (tmr_done) begin
                    to_hit    = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (!run)          state_nxt = IDLE;
                else if (tmr_done) state_nxt = SETTLE;
            end
            CLEAR_ABORT: state_nxt = run ? SETTLE : IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // Accumulator, sample counter, result registers and the sticky error.
    // The average is registered on the CAPTURE->REPORT edge so that it is
    // presented together with avg_valid during the REPORT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc         <= '0;
            smp_cnt     <= '0;
            avg_count   <= '0;
            timeout_err <= 1'b0;
`ifdef THERM_ALARM_EN
            alarm       <= 1'b0;
`endif
        end else begin
            if (state == IDLE && state_nxt != IDLE) timeout_err <= 1'b0;
            else if (to_hit)                        timeout_err <= 1'b1;

            case (state)
                CAPTURE: begin
                    acc     <= acc_sum;
                    smp_cnt <= smp_cnt + 1'b1;
                    if (last_smp) begin
                        avg_count <= avg_new;
`ifdef THERM_ALARM_EN
                        alarm     <= (avg_new > alarm_thresh);
`endif
                    end
                end
                REPORT, CLEAR_ABORT: begin
                    acc     <= '0;
                    smp_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign seq_busy   = (state != IDLE);
    assign ro_en      = (state == SETTLE) || (state == MEASURE) || (state == CAPTURE);
    assign uart_start = (state == REPORT) || (state == WAIT_ACK);
    assign avg_valid  = (state == REPORT);

endmodule

// File: tb/tb_therm_meas_seq.sv
// Directed bench for therm_meas_seq: reset, averaging, UART handshake,
// run stop, gap length, measurement timeout and async reset.
module tb_therm_meas_seq;

    localparam int AVG_LOG2    = 2;
    localparam int SETTLE_CYC  = 16;
    localparam int GAP_CYC     = 8;
    localparam int TIMEOUT_CYC = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       single = 1'b0;
    logic       window_done = 1'b0;
    logic [7:0] latch_count = 8'd0;
    logic       uart_busy = 1'b0;
    logic       ro_en, uart_start, avg_valid, seq_busy, timeout_err;
    logic [7:0] avg_count;
`ifdef THERM_ALARM_EN
    logic [7:0] alarm_thresh = 8'd20;
    logic       alarm;
`endif

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    therm_meas_seq #(
        .AVG_LOG2    (AVG_LOG2),
        .SETTLE_CYC  (SETTLE_CYC),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .single      (single),
        .window_done (window_done),
        .latch_count (latch_count),
        .uart_busy   (uart_busy),
        .ro_en       (ro_en),
        .uart_start  (uart_start),
        .avg_count   (avg_count),
        .avg_valid   (avg_valid),
        .seq_busy    (seq_busy),
        .timeout_err (timeout_err)
`ifdef THERM_ALARM_EN
        ,
        .alarm_thresh(alarm_thresh),
        .alarm       (alarm)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int cyc = 1);
        repeat (cyc) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered at SETTLE cycle 1. A stray window_done on the last SETTLE cycle
    // must be ignored; the real one arrives on MEASURE cycle 2. Returns at
    // SETTLE cycle 1 of the next sample, or at the REPORT cycle if last.
    task automatic sample(input logic [7:0] cnt, input bit last);
        chk("settle_ro_en", 32'(ro_en), 1);
        tick(SETTLE_CYC - 1);
        window_done = 1'b1;
        tick();
        window_done = 1'b0;
        tick();
        window_done = 1'b1;
        latch_count = cnt;
        tick();
        window_done = 1'b0;
        chk("capture_ro_en", 32'(ro_en), 1);
        chk("capture_uart_start", 32'(uart_start), 0);
        tick();
        if (!last) begin
            chk("clear_ro_en", 32'(ro_en), 0);
            tick();
        end
    endtask

    initial begin
        // Reset held with run high: everything quiet.
        run = 1'b1;
        tick(3);
        chk("rst_ro_en", 32'(ro_en), 0);
        chk("rst_uart_start", 32'(uart_start), 0);
        chk("rst_avg_count", 32'(avg_count), 0);
        chk("rst_avg_valid", 32'(avg_valid), 0);
        chk("rst_seq_busy", 32'(seq_busy), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        rst = 1'b1;
        tick();
        chk("start_seq_busy", 32'(seq_busy), 1);

        // Continuous run, stopped during the third sample: 10,11,12,14 -> 47>>2 = 11.
        sample(8'd10, 1'b0);
        sample(8'd11, 1'b0);
        run = 1'b0;
        sample(8'd12, 1'b0);
        sample(8'd14, 1'b1);
        chk("rep_avg_valid", 32'(avg_valid), 1);
        chk("rep_avg_count", 32'(avg_count), 11);
        chk("rep_uart_start", 32'(uart_start), 1);
        chk("rep_ro_en", 32'(ro_en), 0);
        n = int'(uart_start);
        tick();
        chk("avg_valid_pulse", 32'(avg_valid), 0);
        repeat (3) begin
            n += int'(uart_start);
            tick();
        end
        n += int'(uart_start);
        uart_busy = 1'b1;
        tick();
        chk("ack_uart_start_drop", 32'(uart_start), 0);
        chk("uart_start_cycles", 32'(n), 5);
        single = 1'b1;
        tick();
        single = 1'b0;
        tick(88);
        chk("tx_seq_busy", 32'(seq_busy), 1);
        chk("tx_ro_en", 32'(ro_en), 0);
        uart_busy = 1'b0;
        tick();
        chk("gap_seq_busy", 32'(seq_busy), 1);
        tick();
        chk("stop_idle", 32'(seq_busy), 0);
        tick(5);
        chk("single_not_queued", 32'(seq_busy), 0);
        chk("avg_count_hold", 32'(avg_count), 11);
        chk("idle_ro_en", 32'(ro_en), 0);

        // One-shot: 20,30,25,26 -> 101>>2 = 25; busy answers at once.
        single = 1'b1;
        tick();
        single = 1'b0;
        sample(8'd20, 1'b0);
        sample(8'd30, 1'b0);
        sample(8'd25, 1'b0);
        sample(8'd26, 1'b1);
        chk("one_avg_count", 32'(avg_count), 25);
        chk("one_avg_valid", 32'(avg_valid), 1);
        uart_busy = 1'b1;
        tick();
        chk("one_wait_ack_start", 32'(uart_start), 1);
`ifdef THERM_ALARM_EN
        chk("alarm_high", 32'(alarm), 1);
`endif
        tick();
        chk("one_wait_tx_start", 32'(uart_start), 0);
        uart_busy = 1'b0;
        tick(2);
        chk("one_idle", 32'(seq_busy), 0);
        chk("one_timeout_err", 32'(timeout_err), 0);

        // Continuous: 18,18,18,19 -> 73>>2 = 18, then check gap length.
        run = 1'b1;
        tick();
        sample(8'd18, 1'b0);
        sample(8'd18, 1'b0);
        sample(8'd18, 1'b0);
        sample(8'd19, 1'b1);
        chk("cont_avg_count", 32'(avg_count), 18);
        uart_busy = 1'b1;
        tick(2);
        uart_busy = 1'b0;
        tick();
        chk("gap_first_ro_en", 32'(ro_en), 0);
`ifdef THERM_ALARM_EN
        chk("alarm_low", 32'(alarm), 0);
`endif
        tick(GAP_CYC - 1);
        chk("gap_last_ro_en", 32'(ro_en), 0);
        chk("gap_last_busy", 32'(seq_busy), 1);
        tick();
        chk("gap_end_settle", 32'(ro_en), 1);

        // Measurement timeout with run high: no window_done at all.
        tick(SETTLE_CYC - 1 + TIMEOUT_CYC);
        chk("tmo_before", 32'(timeout_err), 0);
        chk("tmo_measure_ro_en", 32'(ro_en), 1);
        tick();
        chk("tmo_set", 32'(timeout_err), 1);
        chk("tmo_abort_ro_en", 32'(ro_en), 0);
        chk("tmo_no_start", 32'(uart_start), 0);
        tick();
        chk("tmo_resettle_ro_en", 32'(ro_en), 1);
        chk("tmo_sticky", 32'(timeout_err), 1);

        // Async reset mid-operation drops outputs without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        chk("arst_ro_en", 32'(ro_en), 0);
        chk("arst_seq_busy", 32'(seq_busy), 0);
        chk("arst_timeout_err", 32'(timeout_err), 0);
        chk("arst_avg_count", 32'(avg_count), 0);
        run = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(2);
        chk("arst_idle", 32'(seq_busy), 0);

        // One-shot timeout: error survives IDLE, clears on the next start.
        single = 1'b1;
        tick();
        single = 1'b0;
        tick(SETTLE_CYC - 1 + TIMEOUT_CYC);
        tick();
        chk("tmo1_set", 32'(timeout_err), 1);
        tick();
        chk("tmo1_idle", 32'(seq_busy), 0);
        tick(3);
        chk("tmo1_held", 32'(timeout_err), 1);
        single = 1'b1;
        tick();
        single = 1'b0;
        chk("tmo1_clear", 32'(timeout_err), 0);
        chk("tmo1_restart", 32'(ro_en), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
